mul_seq_ctrl: RTL

//  - EX-stage sequencer for the combinational M-extension multiplier (MUL/MULH/MULHSU/MULHU).
//  - Registers the operands and inst_type, then holds them stable on the multiplier inputs for LATENCY

---
 rtl/mul_seq_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mul_seq_ctrl.sv
// rtl/mul_seq_ctrl.sv - EX-stage sequencer for the combinational M-extension multiplier
//
// Registers operands and instruction type, holds them on the multiplier inputs
// for LATENCY cycles (multicycle path), captures the product and hands it to
// writeback over a valid/ready handshake. busy stalls the pipeline while an
// operation is in flight.
//
// Optional feature: define MUL_RESULT_CACHE_EN to add a one-entry result cache
// that lets an exact repeat of the last operation skip the EXEC wait.
//
// Ports:
//   clk, rst                        clock (rising edge), async active-high reset
//   req_valid / req_ready           request handshake from EX
//   inst_type, rs1_data, rs2_data   decoded type and operands
//   flush                           pipeline kill, aborts any operation
//   mul_inst_type, mul_rs1, mul_rs2 registered multiplier inputs
//   mul_out                         multiplier result
//   rsp_valid / rsp_ready           result handshake to writeback
//   rsp_data                        captured result
//   busy                            stall request (state != IDLE)

`ifndef INST_MUL
`define INST_MUL    6'd20
`endif
`ifndef INST_MULH
`define INST_MULH   6'd21
`endif
`ifndef INST_MULHSU
`define INST_MULHSU 6'd22
`endif
`ifndef INST_MULHU
`define INST_MULHU  6'd23
`endif

module mul_seq_ctrl #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [5:0]       inst_type,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  input  logic             flush,
  output logic [5:0]       mul_inst_type,
  output logic [WIDTH-1:0] mul_rs1,
  output logic [WIDTH-1:0] mul_rs2,
  input  logic [WIDTH-1:0] mul_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       is_mul;
  logic       fire;

  assign is_mul = (inst_type == `INST_MUL)    || (inst_type == `INST_MULH) ||
                  (inst_type == `INST_MULHSU) || (inst_type == `INST_MULHU);

  // req_ready is a registered copy of (state == IDLE), so it gates fire directly.
  assign fire = req_valid && req_ready && is_mul;

`ifdef MUL_RESULT_CACHE_EN
  logic             c_vld;
  logic [5:0]       c_type;
  logic [WIDTH-1:0] c_rs1;
  logic [WIDTH-1:0] c_rs2;
  logic [WIDTH-1:0] c_res;
  logic             c_hit;

  assign c_hit = c_vld && (c_type == inst_type) && (c_rs1 == rs1_data) &&
                 (c_rs2 == rs2_data);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      req_ready     <= 1'b1;
      busy          <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      mul_inst_type <= 6'd0;
      mul_rs1       <= '0;
      mul_rs2       <= '0;
`ifdef MUL_RESULT_CACHE_EN
      c_vld         <= 1'b0;
      c_type        <= 6'd0;
      c_rs1         <= '0;
      c_rs2         <= '0;
      c_res         <= '0;
`endif
    end else if (flush) begin
      // Kill wins over every transition, including an accept or a capture in
      // the same cycle; the cache is deliberately left untouched.
      state     <= IDLE;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fire) begin
            mul_inst_type <= inst_type;
            mul_rs1       <= rs1_data;
            mul_rs2       <= rs2_data;
            req_ready     <= 1'b0;
            busy          <= 1'b1;
`ifdef MUL_RESULT_CACHE_EN
            if (c_hit) begin
              rsp_data  <= c_res;
              rsp_valid <= 1'b1;
              state     <= DONE;
            end else begin
              cnt   <= CNT_INIT;
              state <= EXEC;
            end
`else
            cnt   <= CNT_INIT;
            state <= EXEC;
`endif
          end
        end

        EXEC: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rsp_data  <= mul_out;
            rsp_valid <= 1'b1;
            state     <= DONE;
`ifdef MUL_RESULT_CACHE_EN
            c_vld  <= 1'b1;
            c_type <= mul_inst_type;
            c_rs1  <= mul_rs1;
            c_rs2  <= mul_rs2;
            c_res  <= mul_out;
`endif
          end
        end

        DONE: begin
          // Returning to IDLE costs a cycle: req_ready only rises afterwards.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
